rx_noise_adder: RTL
===================

# rx_noise_adder

- Adds generated channel noise to the transmitted sample stream and presents the noisy sample to the Rx slicer/equaliser.
- Sits directly downstream of the noise generator, whose output is a signed 8-bit sample plus valid, and downstream of the channel model.
- A small noise FIFO decouples the free-running noise source from the bursty signal stream.
- Each accepted signal sample consumes exactly one noise sample; the sum is saturated, registered and counted.

## Interface
- DATA_W, 8: signed width of signal and output samples.
- NOISE_W, 8: signed width of noise samples.
- FIFO_DEPTH, 4: noise FIFO entries; power of two, at least 2.
- NOISE_SHIFT, 0: arithmetic right shift applied to noise before the add (amplitude scaling).
- PRIME_LEVEL, 2: FIFO occupancy required to leave PRIME; must be ≤ FIFO_DEPTH.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  block enable; low flushes the block and holds it idle.
- noise_in  in  NOISE_W  signed noise sample from the noise generator.
- noise_in_valid  in  1  noise_in is valid this cycle.
- noise_in_ready  out  1  FIFO can accept noise this cycle.
- signal_in  in  DATA_W  signed channel sample.
- signal_in_valid  in  1  signal_in is valid this cycle.
- signal_in_ready  out  1  block will consume signal_in this cycle.
- data_out  out  DATA_W  signed, saturated signal+noise.
- data_out_valid  out  1  data_out is valid; one-cycle pulse per sample, no backpressure.
- sat_count  out  16  number of saturated outputs since reset; sticks at 0xFFFF.

## Operation
- Noise push occurs on noise_in_valid && noise_in_ready.
  - noise_in_ready = en && !full.
  - Noise offered while ready is low is dropped; the generator is free-running.
- Signal accept occurs on signal_in_valid && signal_in_ready.
  - signal_in_ready = en && state==RUN && !empty.
  - Each accept pops one noise entry in the same cycle.
- Arithmetic:
  - Noise is sign-extended to DATA_W+1 bits, then shifted by NOISE_SHIFT (arithmetic shift).
  - The sum signal + noise is formed at DATA_W+1 bits.
  - The result is clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; for DATA_W=8 that is [-128, 127].
  - sat_count increments whenever clamping changes the value.
- State machine:
  - IDLE: en=0. FIFO held empty.
    - en=1 -> PRIME.
  - PRIME: FIFO fills and no signal is accepted.
    - Occupancy ≥ PRIME_LEVEL -> RUN.
  - RUN: normal operation.
    - FIFO empty: signal_in_ready drops and the state stays RUN (underrun stall).
  - Any state with en=0 -> IDLE next cycle, and the FIFO is flushed.
- Push and pop in the same cycle leave occupancy unchanged. Push on full is impossible because ready is low.
- A deassertion of en does not cancel a sample already accepted; its output still appears on the next cycle.

## Timing
- Reset values:
  - data_out=0, data_out_valid=0, sat_count=0.
  - noise_in_ready=0, signal_in_ready=0.
  - State IDLE, FIFO empty.
- Latency: a signal accepted at edge N gives data_out_valid=1 after edge N+1. The result is registered.
- Throughput: one sample per cycle while the FIFO is non-empty.
- Startup: with noise valid every cycle, RUN is entered PRIME_LEVEL+1 cycles after en rises. The first signal_in_ready follows in that same cycle.
- Reset mid-operation: all state returns to its reset value immediately; pending output is discarded.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo depth. The count register is log2(FIFO_DEPTH)+1 bits.

## Structure
- Package rx_noise_pkg holds:
  - the state enum (IDLE, PRIME, RUN);
  - the saturation limit constants derived from DATA_W;
  - SAT_CNT_W=16.
- Sub-module noise_fifo: a synchronous FIFO with push/pop, full/empty, count and a flush input. It is reused elsewhere in the Rx path.
- The top level holds the FSM, the add/saturate stage, the output register and the saturation counter.

## Test plan
- Reset/priming: rst high, then low with en=1 and noise valid every cycle.
  - All outputs stay 0 while in reset.
  - signal_in_ready rises 3 cycles after en (PRIME_LEVEL=2).
- Basic add: signal 10 with noise 5, then signal -20 with noise -3.
  - data_out = 15, then -23, each one cycle after accept.
  - sat_count stays 0.
- Saturation: signal 120 with noise 20, then signal -120 with noise -20.
  - data_out = 127, then -128.
  - sat_count = 2.
- Underrun: noise_in_valid held low with signal_in_valid high.
  - The FIFO drains 4 entries (occupancy reaches 4 after PRIME, since filling continues until full); then signal_in_ready = 0 and no data_out_valid pulses.
  - Noise resumes -> accepts resume the next cycle.
- Scaling: NOISE_SHIFT=2, signal 0 with noise -7.
  - data_out = -2 (arithmetic shift).
- Enable drop mid-stream: en falls in the same cycle as an accept.
  - That sample is still output next cycle.
  - The FIFO is empty, state is IDLE, and the ready signals are 0.
  - Re-enabling re-enters PRIME.

Source files
------------

// File: rtl/rx_noise_adder_pkg.sv
// Shared types and helpers for the Rx noise adder and its noise FIFO.
package rx_noise_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam int SAT_CNT_W = 16;

    // Largest value representable in a signed word of the given width.
    function automatic int sat_max(input int width);
        return (1 << (width - 1)) - 1;
    endfunction

    // Most negative value representable in a signed word of the given width.
    function automatic int sat_min(input int width);
        return -(1 << (width - 1));
    endfunction

endpackage

// File: rtl/rx_noise_adder_fifo.sv
// Small synchronous FIFO with flush, used to buffer free-running noise
// samples until the bursty signal stream consumes them.
module noise_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   cnt;
    logic             do_push;
    logic             do_pop;

    assign full     = (cnt == (PTR_W + 1)'(DEPTH));
    assign empty    = (cnt == '0);
    assign count    = cnt;
    assign pop_data = mem[rd_ptr];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two; flush wins over traffic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (PTR_W + 1)'(1);
                2'b01:   cnt <= cnt - (PTR_W + 1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/rx_noise_adder.sv
// Adds buffered channel noise to the signal stream, saturates the sum,
// registers it and counts how often clamping was needed.
module rx_noise_adder
    import rx_noise_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int NOISE_W     = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int NOISE_SHIFT = 0,
    parameter int PRIME_LEVEL = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [NOISE_W-1:0]   noise_in,
    input  logic                 noise_in_valid,
    output logic                 noise_in_ready,
    input  logic [DATA_W-1:0]    signal_in,
    input  logic                 signal_in_valid,
    output logic                 signal_in_ready,
    output logic [DATA_W-1:0]    data_out,
    output logic                 data_out_valid,
    output logic [SAT_CNT_W-1:0] sat_count
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic signed [DATA_W:0] SAT_HI = (DATA_W + 1)'(sat_max(DATA_W));
    localparam logic signed [DATA_W:0] SAT_LO = (DATA_W + 1)'(sat_min(DATA_W));

    state_t                   state;
    state_t                   state_next;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [CNT_W-1:0]         fifo_count;
    logic [NOISE_W-1:0]       fifo_data;
    logic                     noise_push;
    logic                     signal_accept;
    logic signed [DATA_W:0]   signal_ext;
    logic signed [DATA_W:0]   noise_ext;
    logic signed [DATA_W:0]   noise_scaled;
    logic signed [DATA_W:0]   sum_wide;
    logic [DATA_W-1:0]        sum_sat;
    logic                     sat_hit;

    // Readies are forced low while reset is asserted so nothing is pushed.
    assign noise_in_ready  = en && !fifo_full && !rst;
    assign signal_in_ready = en && (state == RUN) && !fifo_empty;
    assign noise_push      = noise_in_valid && noise_in_ready;
    assign signal_accept   = signal_in_valid && signal_in_ready;

    noise_fifo #(
        .WIDTH (NOISE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_noise_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (!en),
        .push      (noise_push),
        .push_data (noise_in),
        .pop       (signal_accept),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Leave PRIME once enough noise is buffered; dropping en always returns to IDLE.
    always_comb begin
        state_next = state;
        if (!en) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    state_next = PRIME;
                PRIME:   if (fifo_count >= CNT_W'(PRIME_LEVEL)) state_next = RUN;
                RUN:     state_next = RUN;
                default: state_next = IDLE;
            endcase
        end
    end

    // Sign-extend and scale the noise, add one guard bit, then clamp to DATA_W.
    always_comb begin
        signal_ext   = $signed({signal_in[DATA_W-1], signal_in});
        noise_ext    = (DATA_W + 1)'($signed(fifo_data));
        noise_scaled = noise_ext >>> NOISE_SHIFT;
        sum_wide     = signal_ext + noise_scaled;
        sum_sat      = sum_wide[DATA_W-1:0];
        sat_hit      = 1'b0;
        if (sum_wide > SAT_HI) begin
            sum_sat = SAT_HI[DATA_W-1:0];
            sat_hit = 1'b1;
        end else if (sum_wide < SAT_LO) begin
            sum_sat = SAT_LO[DATA_W-1:0];
            sat_hit = 1'b1;
        end
    end

    // Output register and sticky saturation counter; an accepted sample always completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out       <= '0;
            data_out_valid <= 1'b0;
            sat_count      <= '0;
        end else begin
            data_out_valid <= signal_accept;
            if (signal_accept) begin
                data_out <= sum_sat;
                if (sat_hit && (sat_count != '1)) begin
                    sat_count <= sat_count + SAT_CNT_W'(1);
                end
            end
        end
    end

endmodule
